// File: rtl/carfield_ext_req_mux.sv
// carfield_ext_req_mux: arbitrates external request ports onto one master port and routes in-order responses back
module carfield_ext_req_mux #(
    parameter int NumPorts       = 2,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4,
    parameter int FixedPrio      = 0,
    parameter int CntW           = $clog2(MaxOutstanding + 1),
    parameter int IdxW           = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPorts-1:0]           slv_req_valid_i,
    output logic [NumPorts-1:0]           slv_req_ready_o,
    input  logic [NumPorts*DataWidth-1:0] slv_req_data_i,
    output logic [NumPorts-1:0]           slv_rsp_valid_o,
    input  logic [NumPorts-1:0]           slv_rsp_ready_i,
    output logic [NumPorts*DataWidth-1:0] slv_rsp_data_o,
    output logic                          mst_req_valid_o,
    input  logic                          mst_req_ready_i,
    output logic [DataWidth-1:0]          mst_req_data_o,
    output logic [IdxW-1:0]               mst_req_port_o,
    input  logic                          mst_rsp_valid_i,
    output logic                          mst_rsp_ready_o,
    input  logic [DataWidth-1:0]          mst_rsp_data_i,
    output logic [CntW-1:0]               outstanding_o,
    output logic                          unexpected_rsp_o
);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] base_idx, scan_idx, arb_idx, gnt_idx, head_idx;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];
    logic            lock_q, lock_d, unexp_q, unexp_d, init_q;
    logic            arb_found, out_en, full, empty, push, pop;

    // Handshakes stay masked while reset is held and for the first cycle after it
    assign out_en   = !rst_i && !init_q;
    assign full     = cnt_q == CntW'(MaxOutstanding);
    assign empty    = cnt_q == '0;
    assign head_idx = fifo_q[rd_ptr_q];

    assign outstanding_o    = cnt_q;
    assign unexpected_rsp_o = unexp_q;
    assign slv_rsp_data_o   = {NumPorts{mst_rsp_data_i}};

    // Search for the first valid port starting at the round-robin pointer (index 0 in fixed-priority mode)
    always_comb begin
        base_idx  = (FixedPrio != 0) ? '0 : rr_ptr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            scan_idx = IdxW'((int'(base_idx) + i) % NumPorts);
            if (slv_req_valid_i[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // A presented but unaccepted grant is held; new grants need free FIFO space (no same-cycle pop bypass)
    always_comb begin
        gnt_idx         = lock_q ? lock_idx_q : arb_idx;
        mst_req_valid_o = out_en && (lock_q ? slv_req_valid_i[lock_idx_q] : (arb_found && !full));
        mst_req_port_o  = gnt_idx;
        mst_req_data_o  = '0;
        for (int i = 0; i < NumPorts; i++)
            if (gnt_idx == IdxW'(i)) mst_req_data_o = slv_req_data_i[i*DataWidth +: DataWidth];
        slv_req_ready_o          = '0;
        slv_req_ready_o[gnt_idx] = mst_req_valid_o && mst_req_ready_i;
    end

    // Responses belong to the oldest in-flight request
    always_comb begin
        mst_rsp_ready_o           = out_en && !empty && slv_rsp_ready_i[head_idx];
        slv_rsp_valid_o           = '0;
        slv_rsp_valid_o[head_idx] = out_en && !empty && mst_rsp_valid_i;
    end

    // Next-state for arbitration, lock, FIFO pointers, in-flight count and error flag
    always_comb begin
        push       = mst_req_valid_o && mst_req_ready_i;
        pop        = mst_rsp_valid_i && mst_rsp_ready_o;
        lock_d     = push ? 1'b0 : (mst_req_valid_o ? 1'b1 : lock_q);
        lock_idx_d = mst_req_valid_o ? gnt_idx : lock_idx_q;
        rr_ptr_d   = push ? IdxW'((int'(gnt_idx) + 1) % NumPorts) : rr_ptr_q;
        wr_ptr_d   = !push ? wr_ptr_q : (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d   = !pop ? rd_ptr_q : (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
        cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
        unexp_d    = unexp_q || (mst_rsp_valid_i && empty);
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        init_q <= rst_i;
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            unexp_q    <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            unexp_q    <= unexp_d;
        end
    end

    // Originating port of each accepted request, in acceptance order
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= gnt_idx;
    end
endmodule

// File: doc/carfield_ext_req_mux.md
CARFIELD_EXT_REQ_MUX -- requirements
Module: carfield_ext_req_mux

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of external request ports (1..16).
REQ-002 SHALL have parameter DataWidth, default 64, request/response payload width.
REQ-003 SHALL have parameter MaxOutstanding, default 4, in-flight request limit (1..32); CntW = $clog2(MaxOutstanding+1), IdxW = max(1,$clog2(NumPorts)).
REQ-004 SHALL have parameter FixedPrio, default 0; 0 = round-robin, 1 = fixed priority, lowest index wins.
REQ-005 SHALL have one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-006 clk_i  input  1  sole clock, all state on rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 slv_req_valid_i  input  NumPorts  per-port request valid.
REQ-009 slv_req_ready_o  output  NumPorts  per-port request ready.
REQ-010 slv_req_data_i  input  NumPorts x DataWidth  per-port request payload.
REQ-011 slv_rsp_valid_o  output  NumPorts  per-port response valid.
REQ-012 slv_rsp_ready_i  input  NumPorts  per-port response ready.
REQ-013 slv_rsp_data_o  output  NumPorts x DataWidth  response payload, broadcast to all ports.
REQ-014 mst_req_valid_o / mst_req_ready_i  output/input  1  muxed request handshake.
REQ-015 mst_req_data_o  output  DataWidth  muxed request payload.
REQ-016 mst_req_port_o  output  IdxW  index of the port that originated the current request.
REQ-017 mst_rsp_valid_i / mst_rsp_ready_o  input/output  1  muxed response handshake.
REQ-018 mst_rsp_data_i  input  DataWidth  muxed response payload.
REQ-019 outstanding_o  output  CntW  count of in-flight requests.
REQ-020 unexpected_rsp_o  output  1  sticky flag: a response arrived with no request in flight.

Function
REQ-021 A grant SHALL be issued only when outstanding_o < MaxOutstanding and at least one slv_req_valid_i is set.
REQ-022 In round-robin mode, the SHALL grant go to the first valid port at or after rr_ptr, searching upward and wrapping from NumPorts-1 to 0.
REQ-023 mst_req_valid_o, mst_req_data_o and mst_req_port_o SHALL be driven combinationally from the granted port; slv_req_ready_o[g] = mst_req_ready_i, and all other ready outputs SHALL be 0.
REQ-024 Once mst_req_valid_o=1 without a handshake, the grant SHALL be locked in a register until the handshake, even if a higher-priority port becomes valid.
REQ-025 On a request handshake, the SHALL push the granted index into an in-order FIFO of depth MaxOutstanding, set rr_ptr to (g+1) mod NumPorts, and clear the lock.
REQ-026 Responses SHALL be routed to the port at the FIFO head: slv_rsp_valid_o[head] = mst_rsp_valid_i, and mst_rsp_ready_o = slv_rsp_ready_i[head].
REQ-027 On a response handshake, the SHALL pop the FIFO head.
REQ-028 Simultaneous push and pop SHALL leave outstanding_o unchanged; push alone increments it by 1, and pop alone decrements it by 1.
REQ-029 When the FIFO is full, no new grant SHALL be issued in that cycle, even if a pop occurs in the same cycle (no bypass).
REQ-030 When the FIFO is empty, mst_rsp_ready_o SHALL be 0 and all slv_rsp_valid_o SHALL be 0; mst_rsp_valid_i=1 in this state SHALL set unexpected_rsp_o on the next edge, where it stays until reset.
REQ-031 FIFO pointers SHALL wrap modulo MaxOutstanding; the design SHALL be correct for non-power-of-two depths.
REQ-032 In NumPorts=1 mode, the block SHALL be a pass-through with in-flight counting; mst_req_port_o SHALL be 0.

Reset
REQ-033 While rst_i=1, on the clock edge the SHALL clear rr_ptr, lock, FIFO pointers, outstanding_o and unexpected_rsp_o.
REQ-034 During reset and in the first cycle after it, mst_req_valid_o, mst_rsp_ready_o, all slv_req_ready_o and all slv_rsp_valid_o SHALL be 0.
REQ-035 A reset mid-transaction SHALL discard all in-flight entries with no responses replayed; a response arriving after reset with the FIFO empty SHALL set unexpected_rsp_o.

Verification
REQ-036 RR fairness: NumPorts=3, all ports valid continuously, mst_req_ready_i=1, responses returned immediately -> grant order 0,1,2,0,1,2.
REQ-037 Lock: port 1 granted with mst_req_ready_i=0 for 5 cycles while port 0 is raised -> mst_req_port_o stays 1 and mst_req_data_o stays stable until the handshake.
REQ-038 Full: MaxOutstanding=4, 4 requests accepted with no responses -> outstanding_o=4 and mst_req_valid_o=0; one response popped -> a grant resumes on the next cycle.
REQ-039 Ordering: requests from ports 2,0,1 -> three responses delivered to ports 2,0,1 in order; backpressure slv_rsp_ready_i[0]=0 holds mst_rsp_ready_o=0.
REQ-040 Error/reset: with the FIFO empty, mst_rsp_valid_i=1 -> unexpected_rsp_o=1 next cycle; rst_i pulsed with 2 in flight -> outstanding_o=0 and the flag is cleared.
REQ-041 FixedPrio=1: ports 0 and 2 both valid continuously -> port 0 always granted and port 2 starved.
